// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction fetch over a req/ack memory port, instruction
// register, and next-PC selection (sequential, beq/bne, j) for the
// single-issue MIPS-subset datapath. Two-state machine: FETCH then EXEC.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  func,
   output logic        instr_valid,
   input  logic        Jump,
   input  logic        Branch,
   input  logic        Zero,
   input  logic        stall,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] retired
);

   localparam logic [5:0] OP_BNE = 6'b000101;

   typedef enum logic {
      FETCH = 1'b0,
      EXEC  = 1'b1
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] instr_reg, instr_next;
   logic [31:0] retired_reg, retired_next;

   logic [31:0] seq_pc;
   logic [31:0] jump_target;
   logic [31:0] branch_offset;
   logic [31:0] branch_target;
   logic        branch_take;
   logic [31:0] target_pc;

   // Candidate next-PC values; all arithmetic wraps at 32 bits.
   assign seq_pc        = pc_reg + 32'd4;
   assign jump_target   = {seq_pc[31:28], instr_reg[25:0], 2'b00};
   assign branch_offset = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
   assign branch_target = seq_pc + branch_offset;

   // beq takes on Zero, bne on !Zero: the opcode simply inverts the sense.
   assign branch_take = Zero ^ (instr_reg[31:26] == OP_BNE);

   // Next-PC priority: jump beats a taken branch, which beats sequential.
   always_comb begin
      target_pc = seq_pc;
      if (Jump) begin
         target_pc = jump_target;
      end else if (Branch && branch_take) begin
         target_pc = branch_target;
      end
   end

   // State register: FSM state, PC, instruction register, retire counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= FETCH;
         pc_reg      <= RESET_PC;
         instr_reg   <= 32'd0;
         retired_reg <= 32'd0;
      end else begin
         state_reg   <= state_next;
         pc_reg      <= pc_next;
         instr_reg   <= instr_next;
         retired_reg <= retired_next;
      end
   end

   // Next-state logic: capture on ack in FETCH, retire on non-stalled EXEC.
   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      instr_next   = instr_reg;
      retired_next = retired_reg;
      case (state_reg)
         FETCH: begin
            if (imem_ack) begin
               instr_next = imem_rdata;
               state_next = EXEC;
            end
         end
         EXEC: begin
            if (!stall) begin
               pc_next      = target_pc;
               retired_next = retired_reg + 32'd1;
               state_next   = FETCH;
            end
         end
         default: state_next = FETCH;
      endcase
   end

   // Output decode: request only while fetching, valid only while executing,
   // both forced low during reset so a pending fetch is abandoned at once.
   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      if (!rst) begin
         imem_req    = (state_reg == FETCH);
         instr_valid = (state_reg == EXEC);
      end
   end

   assign imem_addr = pc_reg;
   assign pc        = pc_reg;
   assign pc_plus4  = seq_pc;
   assign instr     = instr_reg;
   assign opcode    = instr_reg[31:26];
   assign func      = instr_reg[5:0];
   assign retired   = retired_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: three instances with different reset PCs share
// one stimulus stream; a per-instruction reference model predicts each PC.
module tb_pc_sequencer;

   localparam int ND = 3;
   localparam logic [31:0] RPC [ND] = '{32'h0000_0000, 32'h0FFF_FFFC, 32'hFFFF_FFFC};

   localparam logic [31:0] W_ADD     = 32'h0022_1820;
   localparam logic [31:0] W_J40     = 32'h0800_0010;
   localparam logic [31:0] W_BEQ_M1  = 32'h1022_FFFF;
   localparam logic [31:0] W_BNE_P3  = 32'h1422_0003;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        Jump = 1'b0;
   logic        Branch = 1'b0;
   logic        Zero = 1'b0;
   logic        stall = 1'b0;

   logic        imem_req    [ND];
   logic [31:0] imem_addr   [ND];
   logic [31:0] instr       [ND];
   logic [5:0]  opcode      [ND];
   logic [5:0]  func        [ND];
   logic        instr_valid [ND];
   logic [31:0] pc          [ND];
   logic [31:0] pc_plus4    [ND];
   logic [31:0] retired     [ND];

   int n_checks = 0;
   int n_fail   = 0;
   int n_instr  = 0;

   logic [31:0] m_pc [ND];
   logic [31:0] m_instr;
   logic [31:0] m_retired;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < ND; gi++) begin : g_dut
      pc_sequencer #(.RESET_PC(RPC[gi])) u_dut (
         .clk         (clk),
         .rst         (rst),
         .imem_req    (imem_req[gi]),
         .imem_addr   (imem_addr[gi]),
         .imem_ack    (imem_ack),
         .imem_rdata  (imem_rdata),
         .instr       (instr[gi]),
         .opcode      (opcode[gi]),
         .func        (func[gi]),
         .instr_valid (instr_valid[gi]),
         .Jump        (Jump),
         .Branch      (Branch),
         .Zero        (Zero),
         .stall       (stall),
         .pc          (pc[gi]),
         .pc_plus4    (pc_plus4[gi]),
         .retired     (retired[gi])
      );
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference next PC computed from the instruction-set rules.
   function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                              input logic j, input logic b, input logic z);
      logic [31:0] seq;
      logic [15:0] imm;
      int          off;
      bit          is_bne;
      seq = cur + 32'd4;
      if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
      is_bne = ((w >> 26) == 32'd5);
      if (b && (is_bne ? !z : z)) begin
         imm = w[15:0];
         off = int'($signed(imm)) * 4;
         return seq + 32'(off);
      end
      return seq;
   endfunction

   task automatic check_fetch();
      for (int d = 0; d < ND; d++) begin
         check_val("fetch_req", 32'(imem_req[d]), 32'd1);
         check_val("fetch_valid", 32'(instr_valid[d]), 32'd0);
         check_val("fetch_addr", imem_addr[d], m_pc[d]);
         check_val("fetch_instr_held", instr[d], m_instr);
         check_val("fetch_retired", retired[d], m_retired);
      end
   endtask

   task automatic check_exec();
      for (int d = 0; d < ND; d++) begin
         check_val("exec_req", 32'(imem_req[d]), 32'd0);
         check_val("exec_valid", 32'(instr_valid[d]), 32'd1);
         check_val("exec_instr", instr[d], m_instr);
         check_val("exec_opcode", 32'(opcode[d]), m_instr >> 26);
         check_val("exec_func", 32'(func[d]), m_instr & 32'h3F);
         check_val("exec_pc", pc[d], m_pc[d]);
         check_val("exec_pc_plus4", pc_plus4[d], m_pc[d] + 32'd4);
         check_val("exec_retired", retired[d], m_retired);
      end
   endtask

   // One full instruction: delay wait cycles, ack, nstall stalled EXEC cycles,
   // then the retiring EXEC cycle with the given control inputs.
   task automatic run_instr(input logic [31:0] word, input int delay,
                            input logic j, input logic b, input logic z, input int nstall);
      for (int w = 0; w <= delay; w++) begin
         check_fetch();
         imem_ack   = (w == delay);
         imem_rdata = (w == delay) ? word : $urandom;
         stall      = 1'($urandom);
         Jump       = 1'($urandom);
         Branch     = 1'($urandom);
         Zero       = 1'($urandom);
         @(negedge clk);
      end
      m_instr = word;
      for (int s = 0; s <= nstall; s++) begin
         check_exec();
         imem_ack   = 1'($urandom);
         imem_rdata = $urandom;
         if (s < nstall) begin
            stall  = 1'b1;
            Jump   = 1'($urandom);
            Branch = 1'($urandom);
            Zero   = 1'($urandom);
         end else begin
            stall  = 1'b0;
            Jump   = j;
            Branch = b;
            Zero   = z;
         end
         @(negedge clk);
      end
      for (int d = 0; d < ND; d++) m_pc[d] = model_next(m_pc[d], word, j, b, z);
      m_retired  = m_retired + 32'd1;
      imem_ack   = 1'b0;
      stall      = 1'b0;
      Jump       = 1'b0;
      Branch     = 1'b0;
      Zero       = 1'b0;
      n_instr++;
      $display("instr %0d: word=%h delay=%0d stall=%0d J=%0b B=%0b Z=%0b next_pc0=%h",
               n_instr, word, delay, nstall, j, b, z, m_pc[0]);
   endtask

   // Reset for one cycle, optionally with an ack that must be ignored.
   task automatic do_reset(input logic ack_during);
      rst        = 1'b1;
      imem_ack   = ack_during;
      imem_rdata = $urandom | 32'h1;
      stall      = 1'b0;
      #1;
      for (int d = 0; d < ND; d++) begin
         check_val("rst_req", 32'(imem_req[d]), 32'd0);
         check_val("rst_valid", 32'(instr_valid[d]), 32'd0);
      end
      @(negedge clk);
      for (int d = 0; d < ND; d++) m_pc[d] = RPC[d];
      m_instr   = 32'd0;
      m_retired = 32'd0;
      for (int d = 0; d < ND; d++) begin
         check_val("rst_pc", pc[d], RPC[d]);
         check_val("rst_instr", instr[d], 32'd0);
         check_val("rst_retired", retired[d], 32'd0);
      end
      rst      = 1'b0;
      imem_ack = 1'b0;
      #1;
      for (int d = 0; d < ND; d++) begin
         check_val("post_rst_req", 32'(imem_req[d]), 32'd1);
         check_val("post_rst_addr", imem_addr[d], RPC[d]);
      end
      $display("reset: ack_during=%0b", ack_during);
   endtask

   initial begin
      logic [31:0] word;
      logic [5:0]  op;
      logic        j, b;
      int          pick;

      for (int d = 0; d < ND; d++) m_pc[d] = RPC[d];
      m_instr   = 32'd0;
      m_retired = 32'd0;
      @(negedge clk);
      do_reset(1'b0);

      // First sequential instruction: wrap on instance 2, carry into bit 28 on instance 1.
      run_instr(W_ADD, 0, 1'b0, 1'b0, 1'b0, 0);
      check_val("wrap_addr", imem_addr[2], 32'h0000_0000);
      check_val("carry_addr", imem_addr[1], 32'h1000_0000);

      // Jump, then jump with a taken branch also asserted.
      run_instr(W_J40, 0, 1'b1, 1'b0, 1'b0, 0);
      check_val("jump_hi", imem_addr[1], 32'h1000_0040);
      check_val("jump_lo", imem_addr[0], 32'h0000_0040);
      run_instr(W_J40, 1, 1'b1, 1'b1, 1'b1, 0);
      check_val("jump_prio_hi", imem_addr[1], 32'h1000_0040);
      check_val("jump_prio_lo", imem_addr[0], 32'h0000_0040);

      // Branches at pc 0x40.
      run_instr(W_BEQ_M1, 0, 1'b0, 1'b1, 1'b1, 0);
      check_val("beq_back", imem_addr[0], 32'h0000_0040);
      run_instr(W_BNE_P3, 0, 1'b0, 1'b1, 1'b1, 0);
      check_val("bne_not_taken", imem_addr[0], 32'h0000_0044);
      run_instr(W_J40, 0, 1'b1, 1'b0, 1'b0, 0);
      run_instr(W_BNE_P3, 0, 1'b0, 1'b1, 1'b0, 0);
      check_val("bne_taken", imem_addr[0], 32'h0000_0050);

      // Back-to-back sequential fetch from reset.
      do_reset(1'b0);
      for (int i = 0; i < 3; i++) run_instr(W_ADD, 0, 1'b0, 1'b0, 1'b0, 0);
      check_val("seq_addr", imem_addr[0], 32'h0000_000C);
      check_val("seq_retired", retired[0], 32'd3);

      // Wait states, then a long stall.
      run_instr(W_ADD, 3, 1'b0, 1'b0, 1'b0, 0);
      run_instr(W_ADD, 0, 1'b0, 1'b0, 1'b0, 5);
      check_val("stall_retired", retired[0], 32'd5);

      // Reset during a pending fetch with a late ack.
      imem_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      do_reset(1'b1);

      // Reset while executing.
      imem_ack   = 1'b1;
      imem_rdata = W_BEQ_M1;
      @(negedge clk);
      imem_ack = 1'b0;
      stall    = 1'b1;
      @(negedge clk);
      do_reset(1'b1);

      // Randomized instruction stream.
      for (int i = 0; i < 60; i++) begin
         pick = $urandom_range(0, 4);
         case (pick)
            0: op = 6'd0;
            1: op = 6'd2;
            2: op = 6'd4;
            3: op = 6'd5;
            default: op = 6'($urandom_range(6, 63));
         endcase
         word = {op, 26'($urandom)};
         j = (op == 6'd2);
         b = (op == 6'd4) || (op == 6'd5);
         if ($urandom_range(0, 7) == 0) begin
            j = 1'b1;
            b = 1'b1;
         end
         run_instr(word, $urandom_range(0, 3), j, b, 1'($urandom), $urandom_range(0, 2));
      end
      check_val("rand_retired", retired[0], m_retired);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
